// File: rtl/cmd_segment_pkg.sv
// cmd_segment_pkg: shared BPI command-channel definitions.
//   state_t        - packetiser FSM states
//   HDR_*          - header byte offsets within a frame
//   MAX_PKT_LIMIT  - largest packet count the reassembler accepts
//   FIFO_DEPTH/AW  - command byte buffer geometry
package cmd_segment_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CAPTURE   = 3'd1,
        PLAN      = 3'd2,
        HDR       = 3'd3,
        PAYLOAD   = 3'd4,
        WAIT_CONT = 3'd5,
        FLUSH     = 3'd6
    } state_t;

    localparam logic [1:0] HDR_PACK_NUM = 2'd0;
    localparam logic [1:0] HDR_PACK_CNT = 2'd1;
    localparam logic [1:0] HDR_LENGTH   = 2'd2;

    localparam int MAX_PKT_LIMIT = 6;
    localparam int FIFO_DEPTH    = 2048;
    localparam int FIFO_AW       = 11;

endpackage

// File: rtl/cmd_segment_if.sv
// cmd_segment_if: host/far-end signals of the transmit packetiser.
//   master: drives cmd_din/cmd_din_en (command burst) and cont.
//   slave : the packetiser; drives the frame stream, status pulses and
//           debug state/data_count.
// Handshake: there is no back-pressure. cmd_din is taken on every cycle
// cmd_din_en is high; con_dout is meaningful on every cycle con_dout_en is
// high and is 0 otherwise; cont, done and err are single-cycle pulses.
interface cmd_segment_if;
    import cmd_segment_pkg::*;

    logic [7:0]         cmd_din;
    logic               cmd_din_en;
    logic               cont;
    logic [7:0]         con_dout;
    logic               con_dout_en;
    logic               busy;
    logic               done;
    logic               err;
    state_t             state;
    logic [FIFO_AW-1:0] data_count;

    modport master (
        output cmd_din, cmd_din_en, cont,
        input  con_dout, con_dout_en, busy, done, err, state, data_count
    );

    modport slave (
        input  cmd_din, cmd_din_en, cont,
        output con_dout, con_dout_en, busy, done, err, state, data_count
    );

endinterface

// File: rtl/cmd_segment_fifo.sv
// cmd_segment_fifo: synchronous 2048x8 byte FIFO with registered read data.
//   clk, rst   - clock, synchronous active-high reset (empties the FIFO)
//   wr_en, din - write one byte (ignored when full)
//   rd_en      - pop one byte (ignored when empty); dout valid next cycle
//   data_count - bytes currently stored
module cmd_segment_fifo
    import cmd_segment_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [7:0]         din,
    input  logic               rd_en,
    output logic [7:0]         dout,
    output logic [FIFO_AW-1:0] data_count
);

    logic [7:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;
    logic               wr_ok;
    logic               rd_ok;

    // The packetiser never stores more than MAX_PKT*MAX_LEN bytes, so the
    // 11-bit count never has to represent a completely full buffer.
    assign wr_ok = wr_en && (data_count != '1);
    assign rd_ok = rd_en && (data_count != '0);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            dout       <= '0;
            data_count <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
                dout <= mem[rptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   data_count <= data_count + 1'b1;
                2'b01:   data_count <= data_count - 1'b1;
                default: data_count <= data_count;
            endcase
        end
    end

endmodule

// File: rtl/cmd_segment.sv
// cmd_segment: transmit-side packetiser for the BPI command channel.
// Captures one command burst, splits it into numbered packets of up to
// MAX_LEN bytes and emits each as a frame: pack_num, pack_cnt, length,
// payload. Between packets it waits for a cont pulse (or times out).
//   clk, rst - clock, synchronous active-high reset
//   bus      - cmd_segment_if.slave (burst in, frame out, busy/done/err,
//              debug state and FIFO data_count)
module cmd_segment
    import cmd_segment_pkg::*;
#(
    parameter int MAX_LEN = 255,
    parameter int MAX_PKT = 6,
    parameter int TIMEOUT = 65535
) (
    input logic          clk,
    input logic          rst,
    cmd_segment_if.slave bus
);

    localparam int          PKT   = (MAX_PKT > MAX_PKT_LIMIT) ? MAX_PKT_LIMIT : MAX_PKT;
    localparam logic [10:0] CAP_W = 11'(PKT * MAX_LEN);
    localparam logic [7:0]  LEN_W = 8'(MAX_LEN);
    localparam logic [15:0] TMO_W = 16'(TIMEOUT);

    state_t             state;
    logic [10:0]        total;
    logic [2:0]         pack_num;
    logic [2:0]         pack_cnt;
    logic [7:0]         last_len;
    logic [7:0]         pay_cnt;
    logic [1:0]         hdr_idx;
    logic [15:0]        tmo_cnt;

    logic [2:0]         pn_c;
    logic [10:0]        base_c;
    logic [7:0]         pkt_len;
    logic               wr_en;
    logic               rd_en;
    logic               overlap;
    logic [7:0]         fifo_dout;
    logic [FIFO_AW-1:0] fifo_count;

    // Packet plan without a divider: the smallest k with total <= k*MAX_LEN
    // is the packet count; (k-1)*MAX_LEN bytes precede the last packet.
    always_comb begin
        pn_c   = 3'(PKT);
        base_c = 11'((PKT - 1) * MAX_LEN);
        for (int k = PKT; k >= 1; k--) begin
            if (total <= 11'(k * MAX_LEN)) begin
                pn_c   = 3'(k);
                base_c = 11'((k - 1) * MAX_LEN);
            end
        end
    end

    assign pkt_len = (pack_cnt == pack_num) ? last_len : LEN_W;

    // Bytes beyond the plan capacity are counted but not stored.
    assign wr_en = bus.cmd_din_en &&
                   ((state == IDLE) || ((state == CAPTURE) && (total < CAP_W)));

    // Reads run one cycle ahead of the output register: the first payload
    // byte is fetched while header byte 1 is on the bus.
    assign rd_en = ((state == HDR) && (hdr_idx == HDR_LENGTH)) ||
                   ((state == PAYLOAD) && ((9'(pay_cnt) + 9'd1) < 9'(pkt_len))) ||
                   ((state == FLUSH) && (fifo_count != '0));

    assign overlap = bus.cmd_din_en && (state != IDLE) && (state != CAPTURE);

    cmd_segment_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .din        (bus.cmd_din),
        .rd_en      (rd_en),
        .dout       (fifo_dout),
        .data_count (fifo_count)
    );

    assign bus.state      = state;
    assign bus.data_count = fifo_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            total           <= '0;
            pack_num        <= '0;
            pack_cnt        <= '0;
            last_len        <= '0;
            pay_cnt         <= '0;
            hdr_idx         <= HDR_PACK_NUM;
            tmo_cnt         <= '0;
            bus.con_dout    <= '0;
            bus.con_dout_en <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            bus.done        <= 1'b0;
            bus.err         <= overlap;
            bus.con_dout    <= '0;
            bus.con_dout_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_din_en) begin
                        total    <= 11'd1;
                        bus.busy <= 1'b1;
                        state    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (bus.cmd_din_en) begin
                        // Saturates at CAP+1, enough to flag oversize.
                        if (total <= CAP_W) total <= total + 11'd1;
                    end else if (total > CAP_W) begin
                        state <= FLUSH;
                    end else begin
                        state <= PLAN;
                    end
                end
                PLAN: begin
                    pack_num        <= pn_c;
                    last_len        <= 8'(total - base_c);
                    pack_cnt        <= 3'd1;
                    bus.con_dout    <= {5'd0, pn_c};
                    bus.con_dout_en <= 1'b1;
                    hdr_idx         <= HDR_PACK_CNT;
                    state           <= HDR;
                end
                HDR: begin
                    bus.con_dout_en <= 1'b1;
                    case (hdr_idx)
                        HDR_PACK_NUM: begin
                            bus.con_dout <= {5'd0, pack_num};
                            hdr_idx      <= HDR_PACK_CNT;
                        end
                        HDR_PACK_CNT: begin
                            bus.con_dout <= {5'd0, pack_cnt};
                            hdr_idx      <= HDR_LENGTH;
                        end
                        default: begin
                            bus.con_dout <= pkt_len;
                            pay_cnt      <= '0;
                            state        <= PAYLOAD;
                        end
                    endcase
                end
                PAYLOAD: begin
                    // pkt_len cycles of data, then one closing cycle.
                    if (pay_cnt < pkt_len) begin
                        bus.con_dout    <= fifo_dout;
                        bus.con_dout_en <= 1'b1;
                        pay_cnt         <= pay_cnt + 8'd1;
                    end else if (pack_cnt < pack_num) begin
                        tmo_cnt <= '0;
                        state   <= WAIT_CONT;
                    end else begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                WAIT_CONT: begin
                    if (bus.cont) begin
                        pack_cnt <= pack_cnt + 3'd1;
                        hdr_idx  <= HDR_PACK_NUM;
                        state    <= HDR;
                    end else if (tmo_cnt == TMO_W) begin
                        state <= FLUSH;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                FLUSH: begin
                    if (fifo_count == '0) begin
                        bus.err  <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_segment.sv
module tb_cmd_segment;
  import cmd_segment_pkg::*;

  localparam int MAX_LEN = 4;
  localparam int MAX_PKT = 6;
  localparam int TIMEOUT = 16;

  localparam logic [1:0] K_BYTE = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmd_segment_if bus ();

  cmd_segment #(
    .MAX_LEN (MAX_LEN),
    .MAX_PKT (MAX_PKT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // scoreboard: {kind, byte}
  logic [9:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic take(input logic [9:0] act, input string name);
    logic [9:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: unexpected output %0h with empty queue", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        miscompares++;
        $display("FAIL %s: got %0h expected %0h", name, act, e);
      end
    end
  endtask

  task automatic push_b(input logic [7:0] b);
    exp_q.push_back({K_BYTE, b});
  endtask

  task automatic push_hdr(input logic [7:0] pn, input logic [7:0] pc, input logic [7:0] len);
    push_b(pn);
    push_b(pc);
    push_b(len);
  endtask

  task automatic push_pay(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) push_b(first + 8'(i));
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.con_dout_en) take({K_BYTE, bus.con_dout}, "frame_byte");
      else chk("idle_dout_zero", int'(bus.con_dout), 0);
      if (bus.done) take({K_DONE, 8'h00}, "done_pulse");
      if (bus.err) take({K_ERR, 8'h00}, "err_pulse");
    end
  end

  // drivers
  task automatic send_burst(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.cmd_din    = first + 8'(i);
      bus.cmd_din_en = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.cmd_din_en = 1'b0;
    bus.cmd_din    = 8'h00;
  endtask

  // called in cycle T: header byte 0 must appear at T+2, not T+1
  task automatic check_t2(input logic [7:0] pn, input string name);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_t1_quiet"}, int'(bus.con_dout_en), 0);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_t2_en"}, int'(bus.con_dout_en), 1);
    chk({name, "_t2_byte0"}, int'(bus.con_dout), int'(pn));
  endtask

  task automatic pulse_cont(input bit check, input logic [7:0] pn, input string name);
    @(posedge clk);
    #1;
    bus.cont = 1'b1;
    @(posedge clk);
    #1;
    bus.cont = 1'b0;
    if (check) begin
      @(negedge clk);
      chk({name, "_c1_quiet"}, int'(bus.con_dout_en), 0);
      @(posedge clk);
      @(negedge clk);
      chk({name, "_c2_en"}, int'(bus.con_dout_en), 1);
      chk({name, "_c2_byte0"}, int'(bus.con_dout), int'(pn));
    end
  endtask

  task automatic wait_state(input state_t st, input int max, input string name);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.state == st) break;
    end
    chk({name, "_reached"}, int'(bus.state), int'(st));
  endtask

  task automatic wait_idle(input int max, input string name);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!bus.busy && exp_q.size() == 0) break;
    end
    chk({name, "_busy_low"}, int'(bus.busy), 0);
    chk({name, "_queue_drained"}, exp_q.size(), 0);
    chk({name, "_state_idle"}, int'(bus.state), int'(IDLE));
    chk({name, "_fifo_empty"}, int'(bus.data_count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_din    = 8'h00;
    bus.cmd_din_en = 1'b0;
    bus.cont       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_con_dout", int'(bus.con_dout), 0);
    chk("rst_con_dout_en", int'(bus.con_dout_en), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_state", int'(bus.state), int'(IDLE));
    chk("rst_fifo", int'(bus.data_count), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: ten bytes -> 4 + 4 + 2
    push_hdr(8'h03, 8'h01, 8'h04); push_pay(8'h01, 4);
    push_hdr(8'h03, 8'h02, 8'h04); push_pay(8'h05, 4);
    push_hdr(8'h03, 8'h03, 8'h02); push_pay(8'h09, 2);
    exp_q.push_back({K_DONE, 8'h00});
    send_burst(10, 8'h01);
    check_t2(8'h03, "t1");
    wait_state(WAIT_CONT, 40, "t1_wait1");
    pulse_cont(1'b1, 8'h03, "t1_cont1");
    wait_state(WAIT_CONT, 40, "t1_wait2");
    pulse_cont(1'b1, 8'h03, "t1_cont2");
    wait_idle(40, "t1");

    // 2: single byte, no wait for cont
    push_hdr(8'h01, 8'h01, 8'h01); push_b(8'h55);
    exp_q.push_back({K_DONE, 8'h00});
    send_burst(1, 8'h55);
    check_t2(8'h01, "t2");
    wait_idle(20, "t2");

    // 3: 25 bytes > 6*4: only 24 stored, flushed, err once
    exp_q.push_back({K_ERR, 8'h00});
    send_burst(25, 8'h20);
    @(negedge clk);
    chk("t3_fifo_capped", int'(bus.data_count), 24);
    wait_idle(80, "t3");

    // 4: timeout after first of two packets, then stray cont ignored
    push_hdr(8'h02, 8'h01, 8'h04); push_pay(8'h01, 4);
    exp_q.push_back({K_ERR, 8'h00});
    send_burst(6, 8'h01);
    wait_state(WAIT_CONT, 40, "t4_wait");
    wait_idle(60, "t4");
    repeat (5) @(posedge clk);
    pulse_cont(1'b0, 8'h00, "t4_stray");
    repeat (6) @(negedge clk);
    chk("t4_stray_state", int'(bus.state), int'(IDLE));
    chk("t4_stray_busy", int'(bus.busy), 0);

    // 5: reset during second packet's payload
    push_hdr(8'h03, 8'h01, 8'h04); push_pay(8'h01, 4);
    push_hdr(8'h03, 8'h02, 8'h04); push_b(8'h05);
    send_burst(10, 8'h01);
    wait_state(WAIT_CONT, 40, "t5_wait");
    pulse_cont(1'b1, 8'h03, "t5_cont");
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_dout", int'(bus.con_dout), 0);
    chk("t5_rst_en", int'(bus.con_dout_en), 0);
    chk("t5_rst_busy", int'(bus.busy), 0);
    chk("t5_rst_done", int'(bus.done), 0);
    chk("t5_rst_err", int'(bus.err), 0);
    chk("t5_rst_state", int'(bus.state), int'(IDLE));
    chk("t5_rst_fifo", int'(bus.data_count), 0);
    chk("t5_rst_queue", exp_q.size(), 0);
    push_hdr(8'h01, 8'h01, 8'h02); push_b(8'hAA); push_b(8'hAB);
    exp_q.push_back({K_DONE, 8'h00});
    send_burst(2, 8'hAA);
    check_t2(8'h01, "t5_new");
    wait_idle(20, "t5_new");

    // 6: cont during payload ignored, byte during wait dropped with err
    push_hdr(8'h02, 8'h01, 8'h04); push_pay(8'h11, 4);
    exp_q.push_back({K_ERR, 8'h00});
    push_hdr(8'h02, 8'h02, 8'h02); push_pay(8'h15, 2);
    exp_q.push_back({K_DONE, 8'h00});
    send_burst(6, 8'h11);
    wait_state(PAYLOAD, 20, "t6_payload");
    pulse_cont(1'b0, 8'h00, "t6_early");
    wait_state(WAIT_CONT, 20, "t6_wait");
    @(posedge clk);
    #1;
    bus.cmd_din    = 8'hEE;
    bus.cmd_din_en = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_din_en = 1'b0;
    bus.cmd_din    = 8'h00;
    repeat (4) @(negedge clk);
    chk("t6_still_waiting", int'(bus.state), int'(WAIT_CONT));
    chk("t6_fifo_kept", int'(bus.data_count), 2);
    pulse_cont(1'b1, 8'h02, "t6_cont");
    wait_idle(30, "t6");

    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
